mac_filter_cfg_seq: RTL and testbench
=====================================

Name: mac_filter_cfg_seq

Overview:
AXI4-Lite master sequencer that programs the mac_filter register bank (4 × 32-bit registers at offsets 0x0/0x4/0x8/0xC) from a single start request. It writes all four registers in order and can optionally read them back and compare. It sits between local control logic and the mac_filter S00_AXI slave port, so software does not need to issue the individual register accesses.

Parameters:
C_M_AXI_ADDR_WIDTH, 4, master address width; offsets 0x0–0xC must fit.
C_BASE_ADDR, 0, base address added to every register offset.
C_TIMEOUT_CYCLES, 256, maximum wait per AXI phase before aborting; minimum 2.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  reset; asynchronous, active-low.
start  in  1  one-cycle request; sampled only in IDLE.
mac_addr  in  48  MAC address to program.
ctrl_word  in  32  control register value.
aux_word  in  32  auxiliary register value.
verify_en  in  1  perform the read-back compare after the writes.
busy  out  1  high from the accepted start until done.
done  out  1  one-cycle pulse at the end of the sequence, pass or fail.
err  out  1  sticky error flag; cleared by the next accepted start.
err_code  out  2  0 none, 1 bad BRESP/RRESP, 2 read-back mismatch, 3 timeout.
err_idx  out  2  register index where the error occurred.
m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  write address.
m_axi_awprot  out  3  constant 0.
m_axi_awvalid / m_axi_awready  out/in  1  AW handshake.
m_axi_wdata  out  32  write data.
m_axi_wstrb  out  4  constant 4'hF.
m_axi_wvalid / m_axi_wready  out/in  1  W handshake.
m_axi_bresp  in  2  write response.
m_axi_bvalid / m_axi_bready  in/out  1  B handshake.
m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  read address.
m_axi_arprot  out  3  constant 0.
m_axi_arvalid / m_axi_arready  out/in  1  AR handshake.
m_axi_rdata  in  32  read data.
m_axi_rresp  in  2  read response.
m_axi_rvalid / m_axi_rready  in/out  1  R handshake.

Behaviour:
- Reset (async assert): FSM goes to IDLE. All valid/ready outputs, busy, done, err, err_code, err_idx and the index counter are 0. Addresses and data are 0. A reset asserted mid-transaction drops all valids immediately; there is no completion and no done.
- Image captured on the accepted start:
  - reg0 = mac_addr[31:0]
  - reg1 = {16'h0, mac_addr[47:32]}
  - reg2 = ctrl_word
  - reg3 = aux_word
  - Input changes after capture have no effect.
- Register address = C_BASE_ADDR + 4·idx.
- A start seen while busy is ignored.
- FSM states:
  - IDLE: on start, go to WR_REQ with idx=0, busy=1, err cleared.
  - WR_REQ: AWVALID and WVALID are raised together in the cycle after entry. Each drops independently on its own handshake (valid & ready at a rising edge). AW and W may complete in either order or in the same cycle. Go to WR_RESP once both have completed.
  - WR_RESP: BREADY=1 until BVALID.
    - BRESP≠OKAY → ERR, code 1.
    - Otherwise, if idx=3: go to RD_REQ with idx=0 when verify_en (captured value) is set, else to DONE.
    - Otherwise idx+1 and back to WR_REQ.
  - RD_REQ: ARVALID held until ARREADY, then go to RD_RESP.
  - RD_RESP: RREADY=1 until RVALID.
    - RRESP≠OKAY → ERR, code 1.
    - RDATA ≠ image[idx] → ERR, code 2.
    - Otherwise, if idx=3 go to DONE, else idx+1 and back to RD_REQ.
  - ERR: set err, err_code and err_idx, then go to DONE. err_code holds until the next accepted start.
  - DONE: done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE.
- Valid stability: VALID never deasserts before its handshake, and address/data stay stable while VALID is high. No combinational path from any READY input to any VALID output.
- Timeout:
  - One counter, cleared on every state transition and on every AW/W handshake.
  - It increments while waiting in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - Reaching C_TIMEOUT_CYCLES → ERR, code 3, with all valids dropped. This is the only permitted non-compliant VALID drop.
- Only one outstanding transaction at a time; reads are never issued while a write is in flight.
- Best-case latency with zero-wait slave:
  - 3 cycles per write (request, handshake, response), so 12 cycles for 4 writes.
  - 3 cycles per read.
  - done 1 cycle after the last response.

Test Plan:
- Program: start with mac_addr=48'hAABB_CCDD_EEFF, ctrl=1, aux=32'h1234, verify_en=1, slave always ready → writes in order 0x0=CCDDEEFF, 0x4=0000AABB, 0x8=00000001, 0xC=00001234; 4 reads match; done pulses once; err=0; busy high throughout.
- Split handshakes: AWREADY delayed 3 cycles, WREADY immediate (then swapped) → exactly one AW and one W handshake per register; valids stable until accepted; sequence completes with err=0.
- Slave returns BRESP=SLVERR on register 2 → no access to 0xC; done pulses; err=1, err_code=1, err_idx=2.
- Slave corrupts the read-back of 0x4 to 0 → err_code=2, err_idx=1, no read of 0x8; a second start while busy is ignored (still exactly one done).
- BVALID never asserted, C_TIMEOUT_CYCLES=16 → ERR after 16 wait cycles, err_code=3; a following start with a well-behaved slave clears err and passes.
- ARESETN pulsed low during a WR_RESP wait → all valids and busy go to 0 asynchronously; no done; the next start restarts at idx 0 (address 0x0).

Source files
------------

// File: rtl/mac_filter_cfg_seq.sv
// AXI4-Lite master that writes a 4-register mac_filter image from one start
// request, optionally reads it back and compares, and reports pass/fail.
module mac_filter_cfg_seq #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
   parameter int unsigned C_BASE_ADDR        = 0,
   parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          start,
   input  logic [47:0]                   mac_addr,
   input  logic [31:0]                   ctrl_word,
   input  logic [31:0]                   aux_word,
   input  logic                          verify_en,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [1:0]                    err_code,
   output logic [1:0]                    err_idx,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [31:0]                   m_axi_wdata,
   output logic [3:0]                    m_axi_wstrb,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [31:0]                   m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_ERR, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0][31:0] img_q, img_d;
   logic             verify_q, verify_d;
   logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [AW-1:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d, err_idx_q, err_idx_d;

   logic             aw_hs, w_hs, ar_hs, tmo_hit, err_set;
   logic [1:0]       err_val;
   logic [AW-1:0]    reg_addr;

   assign aw_hs    = awvalid_q & m_axi_awready;
   assign w_hs     = wvalid_q & m_axi_wready;
   assign ar_hs    = arvalid_q & m_axi_arready;
   assign tmo_hit  = (tmo_q == TW'(C_TIMEOUT_CYCLES - 1));
   assign reg_addr = AW'(C_BASE_ADDR) + AW'({idx_q, 2'b00});

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      img_d      = img_q;
      verify_d   = verify_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      arvalid_d  = arvalid_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      err_idx_d  = err_idx_q;
      tmo_d      = tmo_q;
      err_set    = 1'b0;
      err_val    = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WR_REQ;
               idx_d      = 2'd0;
               img_d      = {aux_word, ctrl_word, {16'h0, mac_addr[47:32]}, mac_addr[31:0]};
               verify_d   = verify_en;
               err_d      = 1'b0;
               err_code_d = 2'd0;
               err_idx_d  = 2'd0;
            end
         end
         S_WR_REQ: begin
            // AW and W are launched together once, then retire independently.
            if (!awvalid_q && !wvalid_q && !aw_done_q && !w_done_q) begin
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = reg_addr;
               wdata_d   = img_q[idx_q];
            end
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d   = S_WR_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else if (tmo_hit) begin
               err_set = 1'b1;
               err_val = 2'd3;
            end
         end
         S_WR_RESP: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) begin
                  err_set = 1'b1;
                  err_val = 2'd1;
               end else if (idx_q == 2'd3) begin
                  state_d = verify_q ? S_RD_REQ : S_DONE;
                  idx_d   = 2'd0;
               end else begin
                  state_d = S_WR_REQ;
                  idx_d   = idx_q + 2'd1;
               end
            end else if (tmo_hit) begin
               err_set = 1'b1;
               err_val = 2'd3;
            end
         end
         S_RD_REQ: begin
            if (!arvalid_q) begin
               arvalid_d = 1'b1;
               araddr_d  = reg_addr;
            end
            if (ar_hs) begin
               arvalid_d = 1'b0;
               state_d   = S_RD_RESP;
            end else if (tmo_hit) begin
               err_set = 1'b1;
               err_val = 2'd3;
            end
         end
         S_RD_RESP: begin
            if (m_axi_rvalid) begin
               if (m_axi_rresp != 2'b00) begin
                  err_set = 1'b1;
                  err_val = 2'd1;
               end else if (m_axi_rdata != img_q[idx_q]) begin
                  err_set = 1'b1;
                  err_val = 2'd2;
               end else if (idx_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RD_REQ;
                  idx_d   = idx_q + 2'd1;
               end
            end else if (tmo_hit) begin
               err_set = 1'b1;
               err_val = 2'd3;
            end
         end
         S_ERR:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A timeout abort is the one place valids may fall without a handshake.
      if (err_set) begin
         state_d    = S_ERR;
         err_d      = 1'b1;
         err_code_d = err_val;
         err_idx_d  = idx_q;
         awvalid_d  = 1'b0;
         wvalid_d   = 1'b0;
         arvalid_d  = 1'b0;
         aw_done_d  = 1'b0;
         w_done_d   = 1'b0;
      end

      if (state_d != state_q || aw_hs || w_hs)
         tmo_d = '0;
      else if (state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP})
         tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         img_q      <= '0;
         verify_q   <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= '0;
         err_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         img_q      <= img_d;
         verify_q   <= verify_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         arvalid_q  <= arvalid_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wdata_q    <= wdata_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_idx_q  <= err_idx_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign err           = err_q;
   assign err_code      = err_code_q;
   assign err_idx       = err_idx_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = (state_q == S_WR_RESP);
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == S_RD_RESP);
endmodule

// File: tb/tb_mac_filter_cfg_seq.sv
// Directed bench for mac_filter_cfg_seq: a small AXI4-Lite slave model with
// injectable delays/errors, plus a linear sequence of checked scenarios.
module tb_mac_filter_cfg_seq;
   logic        ACLK = 1'b0, ARESETN = 1'b0, start = 1'b0, verify_en = 1'b0;
   logic [47:0] mac_addr = '0;
   logic [31:0] ctrl_word = '0, aux_word = '0;
   logic        busy, done, err;
   logic [1:0]  err_code, err_idx;
   logic [3:0]  m_axi_awaddr, m_axi_araddr;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
   logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
   logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
   logic [31:0] m_axi_rdata = '0;

   mac_filter_cfg_seq #(.C_M_AXI_ADDR_WIDTH(4), .C_BASE_ADDR(0), .C_TIMEOUT_CYCLES(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mac_addr(mac_addr),
      .ctrl_word(ctrl_word), .aux_word(aux_word), .verify_en(verify_en),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   always #5 ACLK = ~ACLK;

   int tests = 0, fails = 0;
   // slave behaviour knobs (-1 = disabled)
   int aw_delay = 0, w_delay = 0, b_hold_idx = -1, bresp_err_idx = -1, corrupt_idx = -1;
   logic slv_clr = 1'b0;

   // slave state and observation logs
   int          aw_wait, w_wait, aw_cnt, w_cnt, wr_cnt, rd_cnt, done_cnt, stab_err, b_idx, r_idx;
   logic        aw_got, w_got, b_pend, r_pend, aw_hold, w_hold, ar_hold;
   logic [3:0]  aw_a, aw_hold_addr, ar_hold_addr;
   logic [31:0] w_d, w_hold_data;
   logic [31:0] mem [4];
   logic [3:0]  wlog_addr [8];
   logic [31:0] wlog_data [8];
   logic [3:0]  rlog_addr [8];

   // Decisions are made at the falling edge; a handshake predicted here
   // (valid & new ready) completes at the next rising edge.
   always @(negedge ACLK) begin
      if (slv_clr) begin
         aw_cnt = 0; w_cnt = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; stab_err = 0;
      end
      if (slv_clr || !ARESETN) begin
         aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
         aw_hold = 0; w_hold = 0; ar_hold = 0; b_idx = 0; r_idx = 0;
         m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      end else begin
         if (done === 1'b1) done_cnt++;
         if (aw_hold && !(m_axi_awvalid === 1'b1 && m_axi_awaddr === aw_hold_addr)) stab_err++;
         if (w_hold && !(m_axi_wvalid === 1'b1 && m_axi_wdata === w_hold_data)) stab_err++;
         if (ar_hold && !(m_axi_arvalid === 1'b1 && m_axi_araddr === ar_hold_addr)) stab_err++;
         m_axi_bvalid = b_pend && (b_idx != b_hold_idx);
         m_axi_bresp  = (b_idx == bresp_err_idx) ? 2'b10 : 2'b00;
         if (m_axi_bvalid && m_axi_bready) b_pend = 0;
         m_axi_rvalid = r_pend;
         m_axi_rresp  = 2'b00;
         m_axi_rdata  = (r_idx == corrupt_idx) ? 32'h0 : mem[r_idx];
         if (m_axi_rvalid && m_axi_rready) r_pend = 0;
         m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
         if (m_axi_awvalid && !m_axi_awready) aw_wait++;
         aw_hold = m_axi_awvalid && !m_axi_awready;
         aw_hold_addr = m_axi_awaddr;
         if (m_axi_awvalid && m_axi_awready) begin
            aw_wait = 0; aw_cnt++; aw_got = 1; aw_a = m_axi_awaddr;
         end
         m_axi_wready = m_axi_wvalid && (w_wait >= w_delay);
         if (m_axi_wvalid && !m_axi_wready) w_wait++;
         w_hold = m_axi_wvalid && !m_axi_wready;
         w_hold_data = m_axi_wdata;
         if (m_axi_wvalid && m_axi_wready) begin
            w_wait = 0; w_cnt++; w_got = 1; w_d = m_axi_wdata;
         end
         if (aw_got && w_got) begin
            mem[aw_a[3:2]] = w_d;
            if (wr_cnt < 8) begin wlog_addr[wr_cnt] = aw_a; wlog_data[wr_cnt] = w_d; end
            wr_cnt++; b_pend = 1; b_idx = int'(aw_a[3:2]); aw_got = 0; w_got = 0;
         end
         m_axi_arready = m_axi_arvalid;
         ar_hold = 0;
         ar_hold_addr = m_axi_araddr;
         if (m_axi_arvalid && m_axi_arready) begin
            if (rd_cnt < 8) rlog_addr[rd_cnt] = m_axi_araddr;
            rd_cnt++; r_pend = 1; r_idx = int'(m_axi_araddr[3:2]);
         end
      end
   end

   task automatic tick;
      @(negedge ACLK); #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic slv_clear;
      slv_clr = 1'b1; tick; slv_clr = 1'b0;
   endtask

   int cyc, busy_lo, err_at_start;

   // Start a sequence, scramble inputs after capture, wait (bounded) for done.
   task automatic run(input logic [47:0] mac, input logic [31:0] c, input logic [31:0] a,
                      input logic ve, input int restart_at);
      mac_addr = mac; ctrl_word = c; aux_word = a; verify_en = ve;
      start = 1'b1; tick; start = 1'b0;
      mac_addr = 48'h1111_2222_3333; ctrl_word = 32'hDEAD_BEEF; aux_word = 32'h5555_AAAA;
      verify_en = ~ve;
      cyc = 1; busy_lo = 0; err_at_start = int'(err);
      while (done !== 1'b1 && cyc < 200) begin
         if (busy !== 1'b1) busy_lo++;
         if (cyc == restart_at) start = 1'b1;
         tick; start = 1'b0; cyc++;
      end
      chk("done_seen", done, 1'b1);
      chk("busy_during_done", busy, 1'b1);
   endtask

   initial begin
      #1;
      chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
      chk("rst_err", err, 0);        chk("rst_code", err_code, 0);
      chk("rst_idx", err_idx, 0);    chk("rst_awvalid", m_axi_awvalid, 0);
      chk("rst_wvalid", m_axi_wvalid, 0); chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_bready", m_axi_bready, 0); chk("rst_rready", m_axi_rready, 0);
      chk("rst_awaddr", m_axi_awaddr, 0); chk("rst_wdata", m_axi_wdata, 0);
      tick; ARESETN = 1'b1;
      slv_clear;

      // 1: full program + verify, zero-wait slave
      run(48'hAABB_CCDD_EEFF, 32'h1, 32'h1234, 1'b1, -1);
      chk("t1_latency", cyc, 25);
      chk("t1_busy_lo", busy_lo, 0);
      chk("t1_wr_cnt", wr_cnt, 4);
      chk("t1_a0", wlog_addr[0], 4'h0); chk("t1_d0", wlog_data[0], 32'hCCDD_EEFF);
      chk("t1_a1", wlog_addr[1], 4'h4); chk("t1_d1", wlog_data[1], 32'h0000_AABB);
      chk("t1_a2", wlog_addr[2], 4'h8); chk("t1_d2", wlog_data[2], 32'h0000_0001);
      chk("t1_a3", wlog_addr[3], 4'hC); chk("t1_d3", wlog_data[3], 32'h0000_1234);
      chk("t1_rd_cnt", rd_cnt, 4);
      chk("t1_ra3", rlog_addr[3], 4'hC);
      chk("t1_wstrb", m_axi_wstrb, 4'hF);
      tick;
      chk("t1_err", err, 0); chk("t1_busy_after", busy, 0); chk("t1_done_cnt", done_cnt, 1);
      chk("t1_stab", stab_err, 0);

      // 2: split AW/W handshakes, both orders
      for (int k = 0; k < 2; k++) begin
         aw_delay = (k == 0) ? 3 : 0; w_delay = (k == 0) ? 0 : 3;
         slv_clear;
         run(48'h0102_0304_0506, 32'h7, 32'h8, 1'b1, -1);
         tick;
         chk("t2_aw_cnt", aw_cnt, 4); chk("t2_w_cnt", w_cnt, 4);
         chk("t2_stab", stab_err, 0); chk("t2_err", err, 0);
         chk("t2_d1", wlog_data[1], 32'h0000_0102);
      end
      aw_delay = 0; w_delay = 0;

      // 3: SLVERR on register 2
      bresp_err_idx = 2; slv_clear;
      run(48'hAABB_CCDD_EEFF, 32'h1, 32'h1234, 1'b1, -1);
      tick;
      chk("t3_aw_cnt", aw_cnt, 3); chk("t3_rd_cnt", rd_cnt, 0);
      chk("t3_err", err, 1); chk("t3_code", err_code, 1); chk("t3_idx", err_idx, 2);
      chk("t3_done_cnt", done_cnt, 1);
      bresp_err_idx = -1;

      // 4: read-back mismatch at 0x4, plus an ignored start while busy
      corrupt_idx = 1; slv_clear;
      run(48'hAABB_CCDD_EEFF, 32'h1, 32'h1234, 1'b1, 5);
      repeat (4) tick;
      chk("t4_code", err_code, 2); chk("t4_idx", err_idx, 1);
      chk("t4_rd_cnt", rd_cnt, 2); chk("t4_done_cnt", done_cnt, 1);
      chk("t4_wr_cnt", wr_cnt, 4);
      corrupt_idx = -1;

      // 5: BVALID never arrives -> timeout, then a clean rerun clears err
      b_hold_idx = 0; slv_clear;
      run(48'hAABB_CCDD_EEFF, 32'h1, 32'h1234, 1'b0, -1);
      chk("t5_latency", cyc, 20);
      chk("t5_err", err, 1); chk("t5_code", err_code, 3); chk("t5_idx", err_idx, 0);
      chk("t5_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
      b_hold_idx = -1; tick; slv_clear;
      run(48'hAABB_CCDD_EEFF, 32'h1, 32'h1234, 1'b0, -1);
      chk("t5_err_cleared", err_at_start, 0);
      chk("t5_noverify_latency", cyc, 13);
      tick;
      chk("t5_rerun_err", err, 0); chk("t5_rerun_code", err_code, 0);
      chk("t5_rerun_rd", rd_cnt, 0);

      // 6: async reset while waiting for B of register 2
      b_hold_idx = 2; slv_clear;
      mac_addr = 48'hAABB_CCDD_EEFF; ctrl_word = 32'h1; aux_word = 32'h1234; verify_en = 1'b1;
      start = 1'b1; tick; start = 1'b0;
      cyc = 0;
      while (!(wr_cnt == 3 && m_axi_bready === 1'b1) && cyc < 100) begin tick; cyc++; end
      chk("t6_in_wresp", (wr_cnt == 3 && m_axi_bready === 1'b1), 1'b1);
      tick; tick;
      #2 ARESETN = 1'b0;
      #1;
      chk("t6_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready}, 4'b0000);
      chk("t6_busy", busy, 0);
      tick; tick;
      chk("t6_no_done", done_cnt, 0);
      ARESETN = 1'b1; b_hold_idx = -1; slv_clear;
      run(48'hAABB_CCDD_EEFF, 32'h1, 32'h1234, 1'b1, -1);
      tick;
      chk("t6_restart_addr", wlog_addr[0], 4'h0);
      chk("t6_restart_wr", wr_cnt, 4); chk("t6_restart_err", err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
